tcb_lib_arbitrated_multiplexer: RTL and testbench



---
 rtl/tcb_pkg.sv | 44 ++++
 rtl/tcb_if.sv | 21 ++
 rtl/tcb_lib_priority_arbiter.sv | 30 +++
 rtl/tcb_lib_arbitrated_multiplexer.sv | 90 +++++++++
 tb/tb_tcb_lib_arbitrated_multiplexer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcb_pkg.sv
// Shared TCB bus definitions: physical-layer parameter bundle and its defaults.
package tcb_pkg;

    typedef enum logic {
        TCB_REFERENCE,
        TCB_MEMORY
    } tcb_mod_t;

    typedef enum logic {
        TCB_DESCENDING,
        TCB_ASCENDING
    } tcb_ord_t;

    typedef enum logic [1:0] {
        TCB_COMMON_HALF_DUPLEX,
        TCB_COMMON_FULL_DUPLEX,
        TCB_INDEPENDENT_CHANNEL
    } tcb_chn_t;

    typedef struct packed {
        int       DLY;
        int       UNT;
        int       ADR;
        int       DAT;
        int       ALN;
        int       MIN;
        tcb_mod_t MOD;
        tcb_ord_t ORD;
        tcb_chn_t CHN;
    } tcb_phy_t;

    localparam tcb_phy_t TCB_PAR_PHY_DEF = '{
        DLY: 1,
        UNT: 8,
        ADR: 32,
        DAT: 32,
        ALN: 2,
        MIN: 0,
        MOD: TCB_MEMORY,
        ORD: TCB_DESCENDING,
        CHN: TCB_COMMON_HALF_DUPLEX
    };

endpackage

// File: rtl/tcb_if.sv
// TCB bus interface: request channel from manager, ready and response from subordinate.
interface tcb_if #(
    parameter int UNT = 8,
    parameter int ADR = 32,
    parameter int DAT = 32
);
    localparam int BEN = DAT / UNT;

    logic           vld;
    logic           wen;
    logic [ADR-1:0] adr;
    logic [BEN-1:0] ben;
    logic [DAT-1:0] wdt;
    logic           rdy;
    logic [DAT-1:0] rdt;
    logic           err;

    modport man (output vld, wen, adr, ben, wdt, input rdy, rdt, err);
    modport sub (input vld, wen, adr, ben, wdt, output rdy, rdt, err);

endinterface

// File: rtl/tcb_lib_priority_arbiter.sv
// Combinational fixed-priority arbiter: picks the valid port with the lowest PRI value.
module tcb_lib_priority_arbiter #(
    parameter int SPN = 3,
    parameter int SPL = $clog2(SPN),
    parameter int PRI [SPN-1:0] = '{2, 1, 0}
) (
    input  logic [SPN-1:0] vld,
    output logic [SPL-1:0] sel
);

    function automatic logic [SPL-1:0] pick(input logic [SPN-1:0] mask);
        logic [SPL-1:0] idx;
        int             best;
        idx  = '0;
        best = 2147483647;
        for (int i = 0; i < SPN; i++) begin
            if (mask[i] && (PRI[i] < best)) begin
                best = PRI[i];
                idx  = SPL'(i);
            end
        end
        return idx;
    endfunction

    // With nobody requesting, park on the highest-priority port so sel is always defined.
    always_comb begin
        sel = pick((|vld) ? vld : '1);
    end

endmodule

// File: rtl/tcb_lib_arbitrated_multiplexer.sv
// Arbitrated TCB multiplexer: SPN managers share one subordinate; responses return via a DLY-deep routing pipe.
module tcb_lib_arbitrated_multiplexer
    import tcb_pkg::*;
#(
    parameter int DLY = TCB_PAR_PHY_DEF.DLY,
    parameter int UNT = TCB_PAR_PHY_DEF.UNT,
    parameter int ADR = TCB_PAR_PHY_DEF.ADR,
    parameter int DAT = TCB_PAR_PHY_DEF.DAT,
    parameter int SPN = 3,
    parameter int SPL = $clog2(SPN),
    parameter int PRI [SPN-1:0] = '{2, 1, 0}
) (
    input  logic           clk,
    input  logic           rst,
    tcb_if.sub             sub [SPN-1:0],
    tcb_if.man             man,
    output logic [SPL-1:0] sel
);

    localparam int BEN = DAT / UNT;

    logic [SPN-1:0] sub_vld;
    logic           sub_wen [SPN];
    logic [ADR-1:0] sub_adr [SPN];
    logic [BEN-1:0] sub_ben [SPN];
    logic [DAT-1:0] sub_wdt [SPN];

    logic           trn;
    logic           rsp_vld;
    logic [SPL-1:0] rsp_idx;

    tcb_lib_priority_arbiter #(
        .SPN (SPN),
        .SPL (SPL),
        .PRI (PRI)
    ) arbiter (
        .vld (sub_vld),
        .sel (sel)
    );

    for (genvar i = 0; i < SPN; i++) begin : g_port
        assign sub_vld[i] = sub[i].vld;
        assign sub_wen[i] = sub[i].wen;
        assign sub_adr[i] = sub[i].adr;
        assign sub_ben[i] = sub[i].ben;
        assign sub_wdt[i] = sub[i].wdt;

        assign sub[i].rdy = (sel == SPL'(i)) && man.rdy;
        assign sub[i].rdt = (rsp_vld && (rsp_idx == SPL'(i))) ? man.rdt : '0;
        assign sub[i].err = rsp_vld && (rsp_idx == SPL'(i)) && man.err;
    end

    // Idle ports never drive vld, so the selected port's vld alone gives the mux valid.
    assign man.vld = sub_vld[sel];
    assign man.wen = sub_wen[sel];
    assign man.adr = sub_adr[sel];
    assign man.ben = sub_ben[sel];
    assign man.wdt = sub_wdt[sel];

    assign trn = man.vld && man.rdy;

    if (DLY == 0) begin : g_dly0
        assign rsp_vld = trn;
        assign rsp_idx = sel;
    end else begin : g_dlyn
        logic [DLY-1:0] pipe_vld;
        logic [SPL-1:0] pipe_idx [DLY];

        // Every cycle records whether a transfer happened and who issued it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_vld <= '0;
                for (int i = 0; i < DLY; i++) begin
                    pipe_idx[i] <= '0;
                end
            end else begin
                pipe_vld[0] <= trn;
                pipe_idx[0] <= sel;
                for (int i = 1; i < DLY; i++) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                    pipe_idx[i] <= pipe_idx[i-1];
                end
            end
        end

        assign rsp_vld = pipe_vld[DLY-1];
        assign rsp_idx = pipe_idx[DLY-1];
    end

endmodule

// File: tb/tb_tcb_lib_arbitrated_multiplexer.sv
// Scoreboard bench for the arbitrated multiplexer: expected grants/responses queued, negedge monitors compare.
module tb_tcb_lib_arbitrated_multiplexer;

    typedef struct {
        int          port;
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // manager-side stimulus arrays (shared fields for both instances)
    logic        s_vld [3];
    logic        s_wen [3];
    logic [31:0] s_adr [3];
    logic [31:0] s_wdt [3];
    logic        s_rdy [3];
    logic [31:0] s_rdt [3];
    logic        s_err [3];
    logic        i_vld [3];
    logic        i_rdy [3];

    logic        m_vld, m_wen, m_rdy, m_err;
    logic [31:0] m_adr, m_wdt, m_rdt;
    logic [3:0]  m_ben;
    logic [1:0]  sel, i_sel;
    logic        inject = 1'b0;
    logic [31:0] mem [16];

    int   exp_grant [$];
    int   exp_inv   [$];
    rsp_t exp_rsp   [$];
    int   rsp_due   [$];

    tcb_if bus [2:0] ();
    tcb_if man_if ();
    tcb_if ibus [2:0] ();
    tcb_if iman_if ();

    for (genvar g = 0; g < 3; g++) begin : g_con
        assign bus[g].vld  = s_vld[g];
        assign bus[g].wen  = s_wen[g];
        assign bus[g].adr  = s_adr[g];
        assign bus[g].ben  = 4'hF;
        assign bus[g].wdt  = s_wdt[g];
        assign s_rdy[g]    = bus[g].rdy;
        assign s_rdt[g]    = bus[g].rdt;
        assign s_err[g]    = bus[g].err;
        assign ibus[g].vld = i_vld[g];
        assign ibus[g].wen = 1'b0;
        assign ibus[g].adr = s_adr[g];
        assign ibus[g].ben = 4'hF;
        assign ibus[g].wdt = 32'h0;
        assign i_rdy[g]    = ibus[g].rdy;
    end

    assign m_vld      = man_if.vld;
    assign m_wen      = man_if.wen;
    assign m_adr      = man_if.adr;
    assign m_ben      = man_if.ben;
    assign m_wdt      = man_if.wdt;
    assign man_if.rdy = m_rdy;
    assign man_if.rdt = m_rdt;
    assign man_if.err = m_err;

    assign iman_if.rdy = 1'b1;
    assign iman_if.rdt = 32'h0;
    assign iman_if.err = 1'b0;

    tcb_lib_arbitrated_multiplexer #(.DLY(1)) dut (
        .clk (clk),
        .rst (rst),
        .sub (bus),
        .man (man_if),
        .sel (sel)
    );

    tcb_lib_arbitrated_multiplexer #(.DLY(1), .PRI('{0, 1, 2})) dut_inv (
        .clk (clk),
        .rst (rst),
        .sub (ibus),
        .man (iman_if),
        .sel (i_sel)
    );

    // Subordinate model: one-cycle response; idle cycles drive garbage that must never be routed.
    always @(posedge clk) begin
        if (m_vld && m_rdy) begin
            if (m_wen) mem[m_adr[5:2]] <= m_wdt;
            m_rdt <= m_wen ? 32'h0 : mem[m_adr[5:2]];
            m_err <= !m_wen && inject && (m_adr == 32'h4);
        end else begin
            m_rdt <= 32'hDEADBEEF;
            m_err <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Main monitor: ready pattern, grant order and response routing.
    always @(negedge clk) begin
        if (!rst) begin
            int   msel;
            int   nrsp;
            int   rp;
            logic [2:0] rdy_v, exp_rdy;
            msel = 0;
            for (int i = 2; i >= 0; i--) if (s_vld[i]) msel = i;
            exp_rdy = m_rdy ? (3'b001 << msel) : 3'b000;
            rdy_v   = {s_rdy[2], s_rdy[1], s_rdy[0]};
            checkOutput("rdy_pattern", {29'h0, rdy_v}, {29'h0, exp_rdy});
            for (int i = 0; i < 3; i++) begin
                if (s_vld[i] && s_rdy[i]) begin
                    if (exp_grant.size() == 0) begin
                        checkOutput("grant_unexpected", i, 32'hFFFFFFFF);
                    end else begin
                        checkOutput("grant_port", i, exp_grant.pop_front());
                        checkOutput("grant_adr", m_adr, s_adr[i]);
                        if (!s_wen[i]) rsp_due.push_back(cycle + 1);
                    end
                end
            end
            nrsp = 0;
            rp   = 0;
            for (int i = 0; i < 3; i++) begin
                if ((s_rdt[i] != 0) || s_err[i]) begin
                    nrsp++;
                    rp = i;
                end
            end
            if (nrsp > 1) checkOutput("rsp_multi_port", nrsp, 1);
            if (nrsp > 0) begin
                if (exp_rsp.size() == 0) begin
                    checkOutput("rsp_unexpected", s_rdt[rp], 32'h0);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    checkOutput("rsp_port", rp, e.port);
                    checkOutput("rsp_rdt", s_rdt[rp], e.rdt);
                    checkOutput("rsp_err", {31'h0, s_err[rp]}, {31'h0, e.err});
                    if (rsp_due.size() != 0) checkOutput("rsp_cycle", cycle, rsp_due.pop_front());
                end
            end
        end
    end

    // Inverted-priority monitor: grant order only.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (i_vld[i] && i_rdy[i]) begin
                    if (exp_inv.size() == 0) checkOutput("inv_grant_unexpected", i, 32'hFFFFFFFF);
                    else checkOutput("inv_grant_port", i, exp_inv.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input bit inv, input int p, input logic wen,
                                 input logic [31:0] adr, input logic [31:0] wdt);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        if (inv) begin
            i_vld[p] = 1'b1;
        end else begin
            s_wen[p] = wen;
            s_adr[p] = adr;
            s_wdt[p] = wdt;
            s_vld[p] = 1'b1;
        end
        while (!done && n < 50) begin
            @(negedge clk);
            done = inv ? i_rdy[p] : s_rdy[p];
            @(posedge clk);
            #1;
            n++;
        end
        if (inv) i_vld[p] = 1'b0;
        else s_vld[p] = 1'b0;
        if (!done) checkOutput("req_timeout", p, 32'hFFFFFFFF);
    endtask

    function automatic rsp_t mk(input int p, input logic [31:0] d, input logic e);
        rsp_t r;
        r.port = p;
        r.rdt  = d;
        r.err  = e;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_vld[i] = 1'b0; s_wen[i] = 1'b0; s_adr[i] = '0; s_wdt[i] = '0; i_vld[i] = 1'b0;
        end
        m_rdy = 1'b1;
        rst   = 1'b1;

        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_man_vld", {31'h0, m_vld}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_rdt", s_rdt[i], 32'h0);
            checkOutput("reset_err", {31'h0, s_err[i]}, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // simultaneous writes, grant order 0,1,2
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
        fork
            applyStimulus(0, 0, 1'b1, 32'h0, 32'h03020100);
            applyStimulus(0, 1, 1'b1, 32'h4, 32'h13121110);
            applyStimulus(0, 2, 1'b1, 32'hC, 32'h23222120);
        join
        repeat (2) @(posedge clk);
        #1;

        // simultaneous reads, responses routed back one cycle after each grant
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
        exp_rsp.push_back(mk(0, 32'h03020100, 1'b0));
        exp_rsp.push_back(mk(1, 32'h13121110, 1'b0));
        exp_rsp.push_back(mk(2, 32'h23222120, 1'b0));
        fork
            applyStimulus(0, 0, 1'b0, 32'h0, 32'h0);
            applyStimulus(0, 1, 1'b0, 32'h4, 32'h0);
            applyStimulus(0, 2, 1'b0, 32'hC, 32'h0);
        join
        repeat (2) @(posedge clk);
        #1;

        // subordinate stall with ports 1 and 2 pending
        m_rdy = 1'b0;
        exp_grant.push_back(1); exp_grant.push_back(2);
        exp_rsp.push_back(mk(1, 32'h13121110, 1'b0));
        exp_rsp.push_back(mk(2, 32'h23222120, 1'b0));
        fork
            applyStimulus(0, 1, 1'b0, 32'h4, 32'h0);
            applyStimulus(0, 2, 1'b0, 32'hC, 32'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_rdy", {29'h0, s_rdy[2], s_rdy[1], s_rdy[0]}, 32'h0);
                end
                @(posedge clk);
                #1 m_rdy = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // error pass-through on port1's read
        inject = 1'b1;
        exp_grant.push_back(1);
        exp_rsp.push_back(mk(1, 32'h13121110, 1'b1));
        applyStimulus(0, 1, 1'b0, 32'h4, 32'h0);
        repeat (2) @(posedge clk);
        #1 inject = 1'b0;

        // inverted priorities: grant order 2,1,0
        exp_inv.push_back(2); exp_inv.push_back(1); exp_inv.push_back(0);
        fork
            applyStimulus(1, 0, 1'b0, 32'h0, 32'h0);
            applyStimulus(1, 1, 1'b0, 32'h0, 32'h0);
            applyStimulus(1, 2, 1'b0, 32'h0, 32'h0);
        join
        repeat (3) @(posedge clk);
        #1;

        checkOutput("grants_left", exp_grant.size(), 32'h0);
        checkOutput("inv_grants_left", exp_inv.size(), 32'h0);
        checkOutput("rsps_left", exp_rsp.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
